// File: rtl/write_checker.sv
// write_checker: compares observed store traffic against a small table of
// expected {address, data} writes and reports pass, mismatch or timeout.
// The table is loaded while idle. Once armed, the checker watches memwrite
// until every valid entry has been matched, a strict mismatch occurs, or the
// cycle budget runs out.
module write_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_EXP     = 4,
    parameter int ORDERED     = 1,
    parameter int STRICT      = 1,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic              clear,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [15:0]       match_cnt,
    output logic [15:0]       write_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_MISMATCH = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t              state_q;
    logic [NUM_EXP-1:0]  valid_q;
    logic [NUM_EXP-1:0]  hit_q;
    logic [NUM_EXP-1:0]  hit_d;
    logic [ADDR_W-1:0]   exp_addr_q [NUM_EXP];
    logic [DATA_W-1:0]   exp_data_q [NUM_EXP];
    logic [TMO_W-1:0]    tmo_q;
    logic [15:0]         match_cnt_q;
    logic [15:0]         write_cnt_q;
    logic                pass_q;
    logic                fail_q;
    logic                done_q;
    logic [1:0]          fail_code_q;
    logic [ADDR_W-1:0]   fail_addr_q;
    logic [DATA_W-1:0]   fail_data_q;

    logic                cfg_wr_en;
    logic                seek_done;
    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic                all_hit_d;
    logic                tmo_last;

    assign cfg_wr_en = (state_q == S_IDLE) && cfg_we && (int'(cfg_idx) < NUM_EXP);
    assign tmo_last  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Locate the entry the current store would retire and the resulting hit set.
    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
        seek_done = 1'b0;
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (!seek_done && valid_q[i] && !hit_q[i]) begin
                if (exp_addr_q[i] == dataadr && exp_data_q[i] == writedata) begin
                    match_hit = 1'b1;
                    match_idx = IDX_W'(i);
                    seek_done = 1'b1;
                end else if (ORDERED != 0) begin
                    // In ordered mode only the oldest outstanding entry may match.
                    seek_done = 1'b1;
                end
            end
        end
        hit_d = hit_q;
        if (match_hit) begin
            hit_d[match_idx] = 1'b1;
        end
        all_hit_d = ((valid_q & ~hit_d) == '0);
    end

    // Expected-write table payload, written only while idle.
    // NOTE: payload storage has no reset; valid_q alone decides whether an entry is live.
    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            exp_addr_q[cfg_idx] <= cfg_addr;
            exp_data_q[cfg_idx] <= cfg_data;
        end
    end

    // Entry valid bits: cleared only by reset so that clear keeps the table.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (cfg_wr_en) begin
            valid_q[cfg_idx] <= 1'b1;
        end
    end

    // Checker FSM with registered status outputs and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hit_q       <= '0;
            tmo_q       <= '0;
            match_cnt_q <= '0;
            write_cnt_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_code_q <= CODE_NONE;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            hit_q       <= '0;
            tmo_q       <= '0;
            match_cnt_q <= '0;
            write_cnt_q <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_code_q <= CODE_NONE;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        hit_q       <= '0;
                        tmo_q       <= '0;
                        match_cnt_q <= '0;
                        write_cnt_q <= '0;
                        if (valid_q == '0) begin
                            // Nothing to wait for: the test passes trivially.
                            state_q <= S_PASS;
                            pass_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (memwrite) begin
                        if (write_cnt_q != 16'hFFFF) begin
                            write_cnt_q <= write_cnt_q + 16'd1;
                        end
                        if (match_hit) begin
                            hit_q <= hit_d;
                            if (match_cnt_q != 16'hFFFF) begin
                                match_cnt_q <= match_cnt_q + 16'd1;
                            end
                        end
                    end
                    // The store is judged before the timeout in the same cycle.
                    if (memwrite && match_hit && all_hit_d) begin
                        state_q <= S_PASS;
                        pass_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (memwrite && !match_hit && (STRICT != 0)) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= CODE_MISMATCH;
                        fail_addr_q <= dataadr;
                        fail_data_q <= writedata;
                    end else if (tmo_last) begin
                        state_q     <= S_FAIL;
                        fail_q      <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= CODE_TIMEOUT;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                    end
                end
                default: begin
                    // PASS and FAIL hold everything until clear or reset.
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_cnt_q;
    assign write_cnt = write_cnt_q;

endmodule

// File: tb/tb_write_checker.sv
// Directed bench for write_checker. Two instances share stimulus: u_ord is
// ordered/strict with a 20-cycle budget, u_any is unordered/lenient with a
// long budget and a 3-entry table, so one sequence exercises both modes.
module tb_write_checker;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        start;
    logic        clear;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    logic        o_done, o_pass, o_fail;
    logic [1:0]  o_code;
    logic [31:0] o_faddr, o_fdata;
    logic [15:0] o_mcnt, o_wcnt;

    logic        a_done, a_pass, a_fail;
    logic [1:0]  a_code;
    logic [31:0] a_faddr, a_fdata;
    logic [15:0] a_mcnt, a_wcnt;

    int n_chk = 0;
    int n_bad = 0;

    write_checker #(
        .NUM_EXP(4), .ORDERED(1), .STRICT(1), .TIMEOUT_CYC(20)
    ) u_ord (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(o_done), .pass(o_pass), .fail(o_fail), .fail_code(o_code),
        .fail_addr(o_faddr), .fail_data(o_fdata),
        .match_cnt(o_mcnt), .write_cnt(o_wcnt)
    );

    write_checker #(
        .NUM_EXP(3), .ORDERED(0), .STRICT(0), .TIMEOUT_CYC(1000)
    ) u_any (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .clear(clear),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
        .fail_addr(a_faddr), .fail_data(a_fdata),
        .match_cnt(a_mcnt), .write_cnt(a_wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; clear = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        #2;
        check("rst_done", o_done, 0);
        check("rst_pass", o_pass, 0);
        check("rst_fail", o_fail, 0);
        check("rst_code", o_code, 0);
        check("rst_mcnt", o_mcnt, 0);
        check("rst_wcnt", a_wcnt, 0);
        #10;
        reset = 1'b1;

        // Single entry, matching store completes the test.
        cfg(2'd0, 32'd80, 32'd17);
        pulse_start();
        check("t1_run_pass", o_pass, 0);
        wr(32'd80, 32'd17);
        check("t1_pass", o_pass, 1);
        check("t1_done", o_done, 1);
        check("t1_fail", o_fail, 0);
        check("t1_mcnt", o_mcnt, 1);
        check("t1_wcnt", o_wcnt, 1);
        check("t1_any_pass", a_pass, 1);
        wr(32'd1, 32'd1);
        check("t1_hold_wcnt", o_wcnt, 1);
        check("t1_hold_pass", o_pass, 1);

        // Strict mismatch captures the offending store.
        do_clear();
        pulse_start();
        wr(32'd84, 32'd17);
        check("t2_fail", o_fail, 1);
        check("t2_code", o_code, 1);
        check("t2_faddr", o_faddr, 84);
        check("t2_fdata", o_fdata, 17);
        check("t2_done", o_done, 1);
        check("t2_any_fail", a_fail, 0);
        check("t2_any_wcnt", a_wcnt, 1);
        do_clear();
        check("t2_clr_done", o_done, 0);
        check("t2_clr_code", o_code, 0);
        check("t2_clr_wcnt", o_wcnt, 0);

        // Timeout after exactly 20 RUN cycles; table writes in RUN are ignored.
        pulse_start();
        cfg(2'd0, 32'd90, 32'd90);
        idle(18);
        check("t3_fail_early", o_fail, 0);
        tick();
        check("t3_fail", o_fail, 1);
        check("t3_code", o_code, 2);
        check("t3_faddr", o_faddr, 0);
        check("t3_fdata", o_fdata, 0);
        check("t3_done", o_done, 1);

        // Completing match on the timeout cycle wins.
        do_clear();
        pulse_start();
        idle(19);
        wr(32'd80, 32'd17);
        check("t4_pass", o_pass, 1);
        check("t4_fail", o_fail, 0);
        check("t4_any_pass", a_pass, 1);

        // Strict mismatch on the timeout cycle reports mismatch.
        do_clear();
        pulse_start();
        idle(19);
        wr(32'd84, 32'd17);
        check("t4b_code", o_code, 1);
        check("t4b_faddr", o_faddr, 84);

        // Out-of-order stores: unordered passes, ordered fails on 84.
        do_reset();
        cfg(2'd0, 32'd80, 32'd17);
        cfg(2'd1, 32'd84, 32'd9);
        cfg(2'd3, 32'd84, 32'd9);
        pulse_start();
        wr(32'd84, 32'd9);
        check("t5_any_mcnt1", a_mcnt, 1);
        check("t5_any_pass_early", a_pass, 0);
        check("t5_ord_fail", o_fail, 1);
        check("t5_ord_code", o_code, 1);
        check("t5_ord_faddr", o_faddr, 84);
        check("t5_ord_fdata", o_fdata, 9);
        wr(32'd80, 32'd17);
        check("t5_any_pass", a_pass, 1);
        check("t5_any_mcnt", a_mcnt, 2);
        check("t5_any_wcnt", a_wcnt, 2);

        // Duplicate entries each need their own store.
        do_reset();
        cfg(2'd0, 32'd80, 32'd17);
        cfg(2'd1, 32'd80, 32'd17);
        pulse_start();
        wr(32'd80, 32'd17);
        check("t5b_any_pass_early", a_pass, 0);
        check("t5b_any_mcnt1", a_mcnt, 1);
        check("t5b_ord_pass_early", o_pass, 0);
        wr(32'd80, 32'd17);
        check("t5b_any_pass", a_pass, 1);
        check("t5b_ord_pass", o_pass, 1);
        check("t5b_ord_mcnt", o_mcnt, 2);

        // Lenient mode ignores a stray store.
        do_reset();
        cfg(2'd0, 32'd80, 32'd17);
        pulse_start();
        wr(32'd100, 32'd1);
        check("t6_any_fail", a_fail, 0);
        check("t6_any_mcnt0", a_mcnt, 0);
        check("t6_ord_faddr", o_faddr, 100);
        wr(32'd80, 32'd17);
        check("t6_any_pass", a_pass, 1);
        check("t6_any_wcnt", a_wcnt, 2);
        check("t6_any_mcnt", a_mcnt, 1);
        check("t6_ord_wcnt", o_wcnt, 1);

        // Reset mid-RUN abandons the test; table validity is lost.
        do_reset();
        cfg(2'd0, 32'd80, 32'd17);
        cfg(2'd1, 32'd84, 32'd9);
        pulse_start();
        wr(32'd80, 32'd17);
        check("t7_mcnt", o_mcnt, 1);
        check("t7_pass_pre", o_pass, 0);
        reset = 1'b0;
        #1;
        check("t7_rst_mcnt", o_mcnt, 0);
        check("t7_rst_wcnt", o_wcnt, 0);
        check("t7_rst_done", o_done, 0);
        check("t7_rst_any_mcnt", a_mcnt, 0);
        #1;
        reset = 1'b1;
        pulse_start();
        check("t7_empty_pass", o_pass, 1);
        check("t7_empty_done", o_done, 1);
        check("t7_empty_any_pass", a_pass, 1);

        // Clear wins over start: a later matching store must be ignored.
        do_clear();
        cfg(2'd0, 32'd80, 32'd17);
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        wr(32'd80, 32'd17);
        check("t8_pass", o_pass, 0);
        check("t8_wcnt", o_wcnt, 0);
        check("t8_done", o_done, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
